// File: rtl/deconv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deconv_pkg
// Description : Shared FSM encoding, geometry defaults, cfg field positions
//               and slot/strobe index helpers for the deconv column producer.
// Revision    : 1.0 - initial release
// ============================================================================
package deconv_pkg;

    localparam int DEF_PIX_WIDTH       = 8;
    localparam int DEF_SIZE_OF_FEATURE = 8;
    localparam int DEF_SIZE_OF_WEIGHT  = 5;

    localparam int CFG_COLS_LSB = 0;
    localparam int CFG_COLS_MSB = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WLOAD = 3'd1,
        ST_FLOAD = 3'd2,
        ST_MUL   = 3'd3,
        ST_SEND  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Bit offset of a product slot on the data bus.
    function automatic int slot_lsb(input int slot, input int pix_width);
        return slot * 2 * pix_width;
    endfunction

    // First strobe bit of a slot group; one strobe bit covers 4 data bits.
    function automatic int strb_lsb(input int grp, input int taps, input int pix_width);
        return (grp * taps * 2 * pix_width) / 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/deconv_row_mult.sv
`default_nettype none
// ============================================================================
// Module      : deconv_row_mult
// Description : One feature pixel times a whole weight column, W parallel
//               multipliers. Macro DECONV_SIGNED_EN selects signed operands.
// Revision    : 1.0 - initial release
// ============================================================================
module deconv_row_mult
    import deconv_pkg::*;
#(
    parameter int PIX_WIDTH      = DEF_PIX_WIDTH,
    parameter int SIZE_OF_WEIGHT = DEF_SIZE_OF_WEIGHT
) (
    input  logic [PIX_WIDTH-1:0]                  pix,
    input  logic [PIX_WIDTH*SIZE_OF_WEIGHT-1:0]   wcol,
    output logic [2*PIX_WIDTH*SIZE_OF_WEIGHT-1:0] prod
);

    localparam int PROD_W = 2 * PIX_WIDTH;

    for (genvar t = 0; t < SIZE_OF_WEIGHT; t++) begin : g_tap
        logic [PIX_WIDTH-1:0] w_tap;
        logic [PROD_W-1:0]    w_a;
        logic [PROD_W-1:0]    w_b;

        assign w_tap = wcol[t*PIX_WIDTH +: PIX_WIDTH];
`ifdef DECONV_SIGNED_EN
        // Low 2P bits of a product of sign-extended operands is the signed product.
        assign w_a = {{PIX_WIDTH{pix[PIX_WIDTH-1]}}, pix};
        assign w_b = {{PIX_WIDTH{w_tap[PIX_WIDTH-1]}}, w_tap};
`else
        assign w_a = {{PIX_WIDTH{1'b0}}, pix};
        assign w_b = {{PIX_WIDTH{1'b0}}, w_tap};
`endif
        assign prod[t*PROD_W +: PROD_W] = w_a * w_b;
    end

endmodule
`default_nettype wire

// File: rtl/deconv_column_producer.sv
`default_nettype none
// ============================================================================
// Module      : deconv_column_producer
// Description : Builds each feature column's product bus and streams it as
//               F+1 en_shift beats, paced by the consumer's accumn_fin window.
//               Optional macro: DECONV_SIGNED_EN (signed multiply).
// Revision    : 1.0 - initial release
// ============================================================================
module deconv_column_producer
    import deconv_pkg::*;
#(
    parameter int PIX_WIDTH       = DEF_PIX_WIDTH,
    parameter int SIZE_OF_FEATURE = DEF_SIZE_OF_FEATURE,
    parameter int SIZE_OF_WEIGHT  = DEF_SIZE_OF_WEIGHT,
    parameter int N_PIX_IN        = SIZE_OF_FEATURE * SIZE_OF_WEIGHT,
    parameter int STRB_WIDTH      = 2 * PIX_WIDTH * N_PIX_IN / 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       i_param_cfg_feature,
    input  logic                              start_i,
    input  logic                              w_valid_i,
    output logic                              w_ready_o,
    input  logic [PIX_WIDTH*SIZE_OF_WEIGHT-1:0]  w_data_i,
    input  logic                              f_valid_i,
    output logic                              f_ready_o,
    input  logic [PIX_WIDTH*SIZE_OF_FEATURE-1:0] f_data_i,
    input  logic                              accumn_fin_i,
    output logic                              en_shift_o,
    output logic [STRB_WIDTH-1:0]             data_strobe_o,
    output logic [2*PIX_WIDTH*N_PIX_IN-1:0]   data_o,
    output logic                              busy_o,
    output logic                              frame_done_o
);

    localparam int PROD_W    = 2 * PIX_WIDTH;
    localparam int GROUP_W   = PROD_W * SIZE_OF_WEIGHT;
    localparam int DATA_W    = PROD_W * N_PIX_IN;
    localparam int MUL_IDX_W = (SIZE_OF_FEATURE > 1) ? $clog2(SIZE_OF_FEATURE) : 1;
    localparam int BEAT_W    = $clog2(SIZE_OF_FEATURE + 1);

    localparam logic [MUL_IDX_W-1:0] c_last_mul  = MUL_IDX_W'(SIZE_OF_FEATURE - 1);
    localparam logic [BEAT_W-1:0]    c_last_beat = BEAT_W'(SIZE_OF_FEATURE);

    state_t                                r_state;
    logic [15:0]                           r_cols;
    logic [15:0]                           r_col_cnt;
    logic [PIX_WIDTH*SIZE_OF_WEIGHT-1:0]   r_weight;
    logic [PIX_WIDTH*SIZE_OF_FEATURE-1:0]  r_feat;
    logic [DATA_W-1:0]                     r_prod;
    logic [MUL_IDX_W-1:0]                  r_mul_idx;
    logic [BEAT_W-1:0]                     r_beat;
    logic                                  r_seen_rise;

    logic [15:0]          w_cfg_cols;
    logic [15:0]          w_col_next;
    logic [PIX_WIDTH-1:0] w_pix;
    logic [GROUP_W-1:0]   w_row_prod;
    logic                 w_unused_cfg;

    assign w_cfg_cols   = i_param_cfg_feature[CFG_COLS_MSB:CFG_COLS_LSB];
    assign w_unused_cfg = ^i_param_cfg_feature[31:CFG_COLS_MSB+1];
    assign w_col_next   = (r_col_cnt >= r_cols) ? r_cols : r_col_cnt + 16'd1;
    assign w_pix        = r_feat[int'(r_mul_idx)*PIX_WIDTH +: PIX_WIDTH];
    assign data_o       = r_prod;

    deconv_row_mult #(
        .PIX_WIDTH      (PIX_WIDTH),
        .SIZE_OF_WEIGHT (SIZE_OF_WEIGHT)
    ) u_row_mult (
        .pix  (w_pix),
        .wcol (r_weight),
        .prod (w_row_prod)
    );

    // Strobe lanes of one slot group; an out-of-range group yields the flush mask.
    function automatic logic [STRB_WIDTH-1:0] group_mask(input int grp);
        logic [STRB_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (grp < SIZE_OF_FEATURE &&
                i >= strb_lsb(grp, SIZE_OF_WEIGHT, PIX_WIDTH) &&
                i <  strb_lsb(grp + 1, SIZE_OF_WEIGHT, PIX_WIDTH)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cols        <= '0;
            r_col_cnt     <= '0;
            r_weight      <= '0;
            r_feat        <= '0;
            r_prod        <= '0;
            r_mul_idx     <= '0;
            r_beat        <= '0;
            r_seen_rise   <= 1'b0;
            w_ready_o     <= 1'b0;
            f_ready_o     <= 1'b0;
            en_shift_o    <= 1'b0;
            data_strobe_o <= '0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_cols    <= (w_cfg_cols == 16'd0) ? 16'd1 : w_cfg_cols;
                        r_col_cnt <= '0;
                        busy_o    <= 1'b1;
                        w_ready_o <= 1'b1;
                        r_state   <= ST_WLOAD;
                    end
                end
                ST_WLOAD: begin
                    if (w_valid_i && w_ready_o) begin
                        r_weight  <= w_data_i;
                        w_ready_o <= 1'b0;
                        f_ready_o <= 1'b1;
                        r_state   <= ST_FLOAD;
                    end
                end
                ST_FLOAD: begin
                    if (f_valid_i && f_ready_o) begin
                        r_feat    <= f_data_i;
                        f_ready_o <= 1'b0;
                        r_mul_idx <= '0;
                        r_state   <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_prod[slot_lsb(int'(r_mul_idx) * SIZE_OF_WEIGHT, PIX_WIDTH) +: GROUP_W] <= w_row_prod;
                    if (r_mul_idx == c_last_mul) begin
                        en_shift_o    <= 1'b1;
                        data_strobe_o <= group_mask(0);
                        r_beat        <= '0;
                        r_state       <= ST_SEND;
                    end else begin
                        r_mul_idx <= r_mul_idx + MUL_IDX_W'(1);
                    end
                end
                ST_SEND: begin
                    if (r_beat == c_last_beat) begin
                        en_shift_o    <= 1'b0;
                        data_strobe_o <= '0;
                        r_col_cnt     <= w_col_next;
                        if (w_col_next >= r_cols) begin
                            frame_done_o <= 1'b1;
                            busy_o       <= 1'b0;
                            r_state      <= ST_DONE;
                        end else begin
                            r_seen_rise <= 1'b0;
                            r_state     <= ST_WAIT;
                        end
                    end else begin
                        r_beat        <= r_beat + BEAT_W'(1);
                        data_strobe_o <= group_mask(int'(r_beat) + 1);
                    end
                end
                ST_WAIT: begin
                    // A level already high on entry counts as the rising edge.
                    if (!r_seen_rise) begin
                        if (accumn_fin_i) begin
                            r_seen_rise <= 1'b1;
                        end
                    end else if (!accumn_fin_i) begin
                        r_seen_rise <= 1'b0;
                        f_ready_o   <= 1'b1;
                        r_state     <= ST_FLOAD;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_deconv_column_producer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deconv_column_producer
// Description : Directed self-checking bench for deconv_column_producer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deconv_column_producer;

    localparam int PW = 8;
    localparam int F  = 8;
    localparam int W  = 5;
    localparam int DW = 2 * PW * F * W;
    localparam int SW = DW / 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     cfg_r = '0;
    logic            start_i = 1'b0;
    logic            w_valid_i = 1'b0;
    logic            w_ready_o;
    logic [PW*W-1:0] w_data_i = '0;
    logic            f_valid_i = 1'b0;
    logic            f_ready_o;
    logic [PW*F-1:0] f_data_i = '0;
    logic            accumn_fin_i = 1'b0;
    logic            en_shift_o;
    logic [SW-1:0]   data_strobe_o;
    logic [DW-1:0]   data_o;
    logic            busy_o;
    logic            frame_done_o;

    int checks = 0;
    int failures = 0;
    int beat_total = 0;
    int done_total = 0;

    deconv_column_producer dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_param_cfg_feature (cfg_r),
        .start_i             (start_i),
        .w_valid_i           (w_valid_i),
        .w_ready_o           (w_ready_o),
        .w_data_i            (w_data_i),
        .f_valid_i           (f_valid_i),
        .f_ready_o           (f_ready_o),
        .f_data_i            (f_data_i),
        .accumn_fin_i        (accumn_fin_i),
        .en_shift_o          (en_shift_o),
        .data_strobe_o       (data_strobe_o),
        .data_o              (data_o),
        .busy_o              (busy_o),
        .frame_done_o        (frame_done_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (en_shift_o)   beat_total++;
        if (frame_done_o) done_total++;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill(input logic [15:0] v);
        logic [DW-1:0] r;
        r = '0;
        for (int s = 0; s < F * W; s++) r[s*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] model(input logic [PW*F-1:0] f, input logic [PW*W-1:0] w);
        logic [DW-1:0]      r;
        logic [7:0]         a;
        logic [7:0]         b;
        logic [15:0]        p;
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        r = '0;
        for (int k = 0; k < F; k++) begin
            for (int t = 0; t < W; t++) begin
                a = f[k*8 +: 8];
                b = w[t*8 +: 8];
`ifdef DECONV_SIGNED_EN
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
`else
                sa = '0;
                sb = '0;
                p  = {8'h00, a} * {8'h00, b};
`endif
                r[(k*W+t)*16 +: 16] = p;
            end
        end
        return r;
    endfunction

    task automatic start_frame(input logic [31:0] cfg, input logic [PW*W-1:0] wd);
        @(negedge clk);
        cfg_r   = cfg;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 20 && !w_ready_o; i++) @(negedge clk);
        chk("w_ready_up", w_ready_o, 1);
        w_data_i  = wd;
        w_valid_i = 1'b1;
        @(posedge clk);
        #1 w_valid_i = 1'b0;
    endtask

    task automatic give_feature(input logic [PW*F-1:0] fd, input int stall);
        for (int i = 0; i < 40 && !f_ready_o; i++) @(negedge clk);
        chk("f_ready_up", f_ready_o, 1);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_f_ready", f_ready_o, 1);
            chk("stall_en_shift", en_shift_o, 0);
            chk("stall_strobe", data_strobe_o, 0);
        end
        f_data_i  = fd;
        f_valid_i = 1'b1;
        @(posedge clk);
        #1 f_valid_i = 1'b0;
        @(negedge clk);
        chk("f_ready_drop", f_ready_o, 0);
    endtask

    task automatic check_send(input logic [DW-1:0] exp, input logic last);
        logic [SW-1:0] base;
        logic [SW-1:0] m;
        base = '0;
        base[19:0] = 20'hFFFFF;
        for (int i = 0; i < 40 && !en_shift_o; i++) @(negedge clk);
        chk("send_start", en_shift_o, 1);
        for (int b = 0; b <= F; b++) begin
            m = (b < F) ? (base << (20 * b)) : '0;
            chk($sformatf("beat%0d_en", b), en_shift_o, 1);
            chk($sformatf("beat%0d_strobe", b), data_strobe_o, m);
            chk($sformatf("beat%0d_data", b), data_o, exp);
            @(negedge clk);
        end
        chk("send_end_en", en_shift_o, 0);
        chk("send_end_done", frame_done_o, last);
        chk("send_end_busy", busy_o, !last);
    endtask

    initial begin : stim
        logic [DW-1:0] exp;
        int b0;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_en_shift", en_shift_o, 0);
        chk("rst_strobe", data_strobe_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_w_ready", w_ready_o, 0);
        chk("rst_f_ready", f_ready_o, 0);
        chk("rst_frame_done", frame_done_o, 0);
        rst = 1'b0;

        // cfg=1, w=2, f=1..8: group k holds (k+1)*2
        exp = '0;
        for (int k = 0; k < F; k++)
            for (int t = 0; t < W; t++)
                exp[(k*W+t)*16 +: 16] = 16'((k + 1) * 2);
        start_frame(32'd1, 40'h0202020202);
        give_feature(64'h0807060504030201, 0);
        check_send(exp, 1'b1);
        @(negedge clk);
        chk("done_single_pulse", frame_done_o, 0);
        chk("idle_busy", busy_o, 0);

        // Reset during beat 3
        start_frame(32'd1, 40'h0303030303);
        give_feature(64'h0101010101010101, 0);
        for (int i = 0; i < 40 && !en_shift_o; i++) @(negedge clk);
        chk("mid_send_reached", en_shift_o, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en_shift", en_shift_o, 0);
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_strobe", data_strobe_o, 0);
        @(negedge clk);
        rst = 1'b0;
        b0 = beat_total;
        repeat (20) @(negedge clk);
        chk("post_rst_no_beats", 32'(beat_total - b0), 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_w_ready", w_ready_o, 0);
        chk("post_rst_data", data_o, 0);

        // 0xFF x 0xFF
        start_frame(32'd1, 40'hFFFFFFFFFF);
        give_feature(64'hFFFFFFFFFFFFFFFF, 0);
`ifdef DECONV_SIGNED_EN
        check_send(fill(16'h0001), 1'b1);
`else
        check_send(fill(16'hFE01), 1'b1);
`endif

        // 0xFF x 0x02
        start_frame(32'd1, 40'h0202020202);
        give_feature(64'hFFFFFFFFFFFFFFFF, 0);
`ifdef DECONV_SIGNED_EN
        check_send(fill(16'hFFFE), 1'b1);
`else
        check_send(fill(16'h01FE), 1'b1);
`endif

        // cfg=3: accumn_fin pacing, pre-raised fin, FLOAD stall
        start_frame(32'd3, 40'h0504030201);
        give_feature(64'h100F0E0D0C0B0A09, 0);
        check_send(model(64'h100F0E0D0C0B0A09, 40'h0504030201), 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("wait_fin_low", f_ready_o, 0);
            @(negedge clk);
        end
        accumn_fin_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wait_fin_high", f_ready_o, 0);
        end
        accumn_fin_i = 1'b0;
        @(negedge clk);
        chk("fload_after_fall", f_ready_o, 1);
        give_feature(64'h7F605040302010FF, 0);
        accumn_fin_i = 1'b1;
        check_send(model(64'h7F605040302010FF, 40'h0504030201), 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("wait_prehigh", f_ready_o, 0);
            @(negedge clk);
        end
        accumn_fin_i = 1'b0;
        @(negedge clk);
        chk("prehigh_counts_as_rise", f_ready_o, 1);
        give_feature(64'h80C0E0F001020304, 4);
        check_send(model(64'h80C0E0F001020304, 40'h0504030201), 1'b1);

        // cfg=0 behaves as one column
        start_frame(32'd0, 40'h0101010101);
        give_feature(64'h1122334455667788, 0);
        check_send(model(64'h1122334455667788, 40'h0101010101), 1'b1);

        // cfg=2 with start_i pulses while busy
        repeat (2) @(negedge clk);
        b0 = beat_total;
        d0 = done_total;
        start_frame(32'd2, 40'h0101010101);
        give_feature(64'h0807060504030201, 0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check_send(model(64'h0807060504030201, 40'h0101010101), 1'b0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        accumn_fin_i = 1'b1;
        @(negedge clk);
        accumn_fin_i = 1'b0;
        give_feature(64'h1817161514131211, 0);
        check_send(model(64'h1817161514131211, 40'h0101010101), 1'b1);
        repeat (20) @(negedge clk);
        chk("cfg2_beats", 32'(beat_total - b0), 18);
        chk("cfg2_done_pulses", 32'(done_total - d0), 1);
        chk("cfg2_idle_busy", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
